aes_multimode_selftest_ctrl: RTL and testbench
==============================================

Name: aes_multimode_selftest_ctrl

Overview:
- Parametrised sequencer for the iterative AES encryption/decryption cores.
- Generalises the free-running per-mode round counters of the current top into one start/busy/done engine, with run-time selection of 128/192/256 mode.
- Runs NUM_VEC chained encrypt-then-decrypt passes, where ciphertext k becomes plaintext k+1. Each round-trip is checked against its plaintext and failures are counted.
- Drives round_idx/pt_out into the shared cores and exposes results plus a selectable display byte for the seven-segment path.

Parameters:
- DATA_W, 128, block width in bits; must be a multiple of 8.
- CNT_W, 6, round_idx width; must hold 2*NR256.
- NR128, 10, round count for mode 0.
- NR192, 12, round count for mode 1.
- NR256, 14, round count for mode 2 and 3.
- NUM_VEC, 4, number of chained vectors per run; minimum 1.
- Derived localparams: VEC_W = clog2(NUM_VEC+1); SEL_W = clog2(DATA_W/8).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, run request; sampled in IDLE only.
- abort, in, 1, cancels the run in progress.
- mode, in, 2, key size select: 0=128, 1=192, 2 or 3=256. Latched at accepted start.
- seed, in, DATA_W, plaintext for vector 0. Latched at accepted start.
- enc_data, in, DATA_W, encryption core output for current round_idx.
- dec_data, in, DATA_W, decryption core output for current round_idx.
- round_idx, out, CNT_W, round counter to the cores. 0=load; 1..Nr=encryption; Nr+1..2Nr=decryption.
- pt_out, out, DATA_W, plaintext presented to the cores.
- busy, out, 1, high from the cycle after accepted start until DONE.
- done, out, 1, one-cycle pulse at run completion.
- pass, out, 1, high when the last completed run had err_cnt==0.
- err_cnt, out, VEC_W, number of mismatching vectors in the current/last run.
- last_ct, out, DATA_W, last captured ciphertext.
- disp_sel, in, SEL_W, byte index into last_ct; 0 = bits[7:0].
- disp_byte, out, 8, selected byte of last_ct; combinational.

Behaviour:
- Reset values (rst low, async): state IDLE, round_idx 0, pt_out 0, busy 0, done 0, pass 0, err_cnt 0, last_ct 0, vector index 0, captures 0.
- Nr = NR128/NR192/NR256 selected from the latched mode.
- IDLE:
  - start=1 (abort=0) latches mode and seed, clears err_cnt and pass, goes to LOAD.
  - Otherwise holds; round_idx stays 0.
- LOAD (1 cycle):
  - round_idx=0; pt_out = seed for vector 0, else the captured ciphertext of the previous vector.
  - busy=1.
- ENC (Nr cycles): round_idx increments 1..Nr. On the edge leaving round_idx==Nr, enc_data is captured into enc_capt and last_ct.
- DEC (Nr cycles): round_idx Nr+1..2Nr. On the edge leaving round_idx==2Nr, dec_data is captured into dec_capt.
- CHECK (1 cycle):
  - If dec_capt != pt_out, err_cnt increments (saturates at NUM_VEC).
  - If vector index == NUM_VEC-1, go to DONE; else increment vector index and go to LOAD.
- DONE (1 cycle): done=1, busy=0, pass=(err_cnt==0), round_idx=0; then IDLE.
- Latency:
  - 2Nr+2 cycles per vector.
  - done asserts NUM_VEC*(2Nr+2)+1 cycles after the start edge (mode 0, NUM_VEC=4: cycle 89).
- start while busy is ignored, including start coincident with DONE.
- mode/seed changes while busy are ignored until the next start.
- abort=1 in any non-IDLE state:
  - Next state IDLE, round_idx 0, busy 0, no done pulse.
  - pass forced 0; err_cnt and last_ct keep the values reached.
  - abort has priority over start.
- rst asserted mid-run: immediate return to reset values; no done pulse.
- Width rules:
  - round_idx never exceeds 2*Nr.
  - Vector index wraps only via reset to 0 at start.
  - All compares are full DATA_W equality.
- disp_byte = last_ct[8*disp_sel +: 8]. disp_sel >= DATA_W/8 yields 0.

Test Plan:
- Mode 0, seed 00112233445566778899aabbccddeeff, cores keyed 000102..0f, NUM_VEC=1:
  - round_idx steps 0,1..20; last_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - done pulses at cycle 23; pass=1, err_cnt=0.
  - disp_sel=0 gives 5a.
- Mode 1 then mode 2, same seed, keys 000102..17 and 000102..1f:
  - last_ct=dda97ca4864cdfe06eaf70a0ec0d7191 (done at cycle 27).
  - Then last_ct=8ea2b7ca516745bfeafc49904b496089 (done at cycle 31).
  - Mode 3 behaves identically to mode 2.
- NUM_VEC=4, mode 0: pt_out of vector 1 equals 69c4e0d86a7b0430d8cdb78070b4c55a; done at cycle 89; pass=1.
- Decryption model corrupted (dec_data bit 0 flipped) on vectors 1 and 3: err_cnt=2 at done, pass=0.
- abort at round_idx=7: next cycle IDLE, busy=0, no done, pass=0. A fresh start then completes normally.
- rst pulled low at round_idx=15 with start held high: all outputs return to reset values immediately. After rst rises a new run begins; start pulses during busy have no effect.

Source files
------------

// File: rtl/aes_multimode_selftest_ctrl.sv
// aes_multimode_selftest_ctrl
// Start/busy/done sequencer for the shared iterative AES encryption and decryption cores.
// One run chains NUM_VEC encrypt-then-decrypt round trips: ciphertext k becomes plaintext k+1.
// Each decrypted result is compared with its plaintext, and mismatches are counted.
module aes_multimode_selftest_ctrl #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned NR128   = 10,
    parameter int unsigned NR192   = 12,
    parameter int unsigned NR256   = 14,
    parameter int unsigned NUM_VEC = 4,
    localparam int unsigned VEC_W  = $clog2(NUM_VEC + 1),
    localparam int unsigned SEL_W  = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] enc_data,
    input  logic [DATA_W-1:0] dec_data,
    output logic [CNT_W-1:0]  round_idx,
    output logic [DATA_W-1:0] pt_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [VEC_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] last_ct,
    input  logic [SEL_W-1:0]  disp_sel,
    output logic [7:0]        disp_byte
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StEnc,
        StDec,
        StCheck,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  round_q, round_d;
    logic [DATA_W-1:0] pt_q, pt_d;
    logic [DATA_W-1:0] enc_capt_q, enc_capt_d;
    logic [DATA_W-1:0] dec_capt_q, dec_capt_d;
    logic [DATA_W-1:0] last_ct_q, last_ct_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [VEC_W-1:0]  err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [CNT_W-1:0]  nr;
    logic [CNT_W-1:0]  nr2;

    // Round count for the latched key size; modes 2 and 3 both mean 256-bit keys.
    always_comb begin
        nr  = CNT_W'(NR256);
        nr2 = CNT_W'(2 * NR256);
        unique case (mode_q)
            2'd0: begin
                nr  = CNT_W'(NR128);
                nr2 = CNT_W'(2 * NR128);
            end
            2'd1: begin
                nr  = CNT_W'(NR192);
                nr2 = CNT_W'(2 * NR192);
            end
            default: begin
                nr  = CNT_W'(NR256);
                nr2 = CNT_W'(2 * NR256);
            end
        endcase
    end

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        round_d    = round_q;
        pt_d       = pt_q;
        enc_capt_d = enc_capt_q;
        dec_capt_d = dec_capt_q;
        last_ct_d  = last_ct_q;
        vec_d      = vec_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;

        if (abort && (state_q != StIdle)) begin
            // Abandon the run. The error count and last ciphertext keep their current values.
            state_d = StIdle;
            round_d = '0;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    round_d = '0;
                    if (start && !abort) begin
                        mode_d  = mode;
                        pt_d    = seed;
                        vec_d   = '0;
                        err_d   = '0;
                        pass_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    round_d = CNT_W'(1);
                    state_d = StEnc;
                end
                StEnc: begin
                    round_d = round_q + CNT_W'(1);
                    if (round_q == nr) begin
                        enc_capt_d = enc_data;
                        last_ct_d  = enc_data;
                        state_d    = StDec;
                    end
                end
                StDec: begin
                    if (round_q == nr2) begin
                        dec_capt_d = dec_data;
                        round_d    = '0;
                        state_d    = StCheck;
                    end else begin
                        round_d = round_q + CNT_W'(1);
                    end
                end
                StCheck: begin
                    round_d = '0;
                    if ((dec_capt_q != pt_q) && (err_q != VEC_W'(NUM_VEC))) begin
                        err_d = err_q + VEC_W'(1);
                    end
                    if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                        state_d = StDone;
                    end else begin
                        // The ciphertext just produced becomes the next plaintext.
                        vec_d   = vec_q + VEC_W'(1);
                        pt_d    = enc_capt_q;
                        state_d = StLoad;
                    end
                end
                StDone: begin
                    round_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    round_d = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            round_q    <= '0;
            pt_q       <= '0;
            enc_capt_q <= '0;
            dec_capt_q <= '0;
            last_ct_q  <= '0;
            vec_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            round_q    <= round_d;
            pt_q       <= pt_d;
            enc_capt_q <= enc_capt_d;
            dec_capt_q <= dec_capt_d;
            last_ct_q  <= last_ct_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    // Byte selection for the display path. An out-of-range index yields zero.
    always_comb begin
        disp_byte = 8'h00;
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            if (32'(disp_sel) == i) begin
                disp_byte = last_ct_q[8*i +: 8];
            end
        end
    end

    assign round_idx = round_q;
    assign pt_out    = pt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign last_ct   = last_ct_q;

endmodule

// File: tb/tb_aes_multimode_selftest_ctrl.sv
// tb_aes_multimode_selftest_ctrl
// Directed bench covering a single-vector instance and a four-vector instance.
// The AES cores are modelled as a lookup: the FIPS-197 answers for the known seed, and a
// rotate-xor mapping for any other plaintext. Core outputs are valid only at the round
// where the controller should capture them.
module tb_aes_multimode_selftest_ctrl;

    localparam logic [127:0] SEED = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KX   = 128'h0123456789abcdeffedcba9876543210;

    logic         clk = 1'b0;
    logic         rst;
    logic         start1, start4, abort;
    logic [1:0]   mode;
    logic [127:0] seed;
    logic [3:0]   disp_sel;

    logic [5:0]   ri1, ri4;
    logic [127:0] pt1, pt4, last1, last4, enc1, dec1, enc4, dec4;
    logic         busy1, busy4, done1, done4, pass1, pass4;
    logic [0:0]   err1;
    logic [2:0]   err4;
    logic [7:0]   disp1, disp4;

    // Core model state.
    logic [1:0]   core_mode;
    logic         corrupt_en;
    logic [127:0] bad_a, bad_b;

    // Observation mux selecting which instance a test looks at.
    logic         sel4;
    logic [5:0]   ob_ri;
    logic [127:0] ob_pt, ob_last;
    logic         ob_busy, ob_done, ob_pass;
    logic [2:0]   ob_err;

    int total = 0;
    int bad   = 0;
    logic [127:0] chain_last;

    always #5 clk = ~clk;

    function automatic int nr_of(input logic [1:0] m);
        return (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
    endfunction

    function automatic logic [127:0] fake_enc(input logic [127:0] pt, input logic [1:0] m);
        if (pt == SEED) return (m == 2'd0) ? C128 : (m == 2'd1) ? C192 : C256;
        return {pt[119:0], pt[127:120]} ^ KX;
    endfunction

    function automatic logic [127:0] dec_flip(input logic [127:0] pt);
        return (corrupt_en && (pt == bad_a || pt == bad_b)) ? 128'd1 : 128'd0;
    endfunction

    assign enc1 = (int'(ri1) == nr_of(core_mode)) ? fake_enc(pt1, core_mode) : ~pt1;
    assign dec1 = (int'(ri1) == 2 * nr_of(core_mode)) ? (pt1 ^ dec_flip(pt1)) : ~pt1;
    assign enc4 = (int'(ri4) == nr_of(core_mode)) ? fake_enc(pt4, core_mode) : ~pt4;
    assign dec4 = (int'(ri4) == 2 * nr_of(core_mode)) ? (pt4 ^ dec_flip(pt4)) : ~pt4;

    assign ob_ri   = sel4 ? ri4 : ri1;
    assign ob_pt   = sel4 ? pt4 : pt1;
    assign ob_last = sel4 ? last4 : last1;
    assign ob_busy = sel4 ? busy4 : busy1;
    assign ob_done = sel4 ? done4 : done1;
    assign ob_pass = sel4 ? pass4 : pass1;
    assign ob_err  = sel4 ? err4 : {2'b00, err1};

    aes_multimode_selftest_ctrl #(.NUM_VEC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .mode(mode), .seed(seed),
        .enc_data(enc1), .dec_data(dec1), .round_idx(ri1), .pt_out(pt1), .busy(busy1),
        .done(done1), .pass(pass1), .err_cnt(err1), .last_ct(last1), .disp_sel(disp_sel),
        .disp_byte(disp1)
    );

    aes_multimode_selftest_ctrl #(.NUM_VEC(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort), .mode(mode), .seed(seed),
        .enc_data(enc4), .dec_data(dec4), .round_idx(ri4), .pt_out(pt4), .busy(busy4),
        .done(done4), .pass(pass4), .err_cnt(err4), .last_ct(last4), .disp_sel(disp_sel),
        .disp_byte(disp4)
    );

    // Pulse start across one rising edge; returns #1 after that edge (cycle 0).
    task automatic drive_start(input bit use4);
        @(negedge clk);
        if (use4) start4 = 1'b1;
        else      start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // From cycle 0, wait for done (bounded). Optionally check the round_idx sequence of the
    // first vector and hold start high throughout the run. Checks that done is one cycle wide.
    task automatic wait_done(input int nr, input bit chk_ri, input bit hold_start,
                             output int dcyc, output logic [127:0] pt22);
        int cyc = 0;
        dcyc = -1;
        pt22 = '0;
        total++;
        if (ob_ri !== 6'd0 || ob_busy !== 1'b1) begin
            bad++;
            $display("FAIL load_cycle: round_idx=%0d busy=%b want 0/1", ob_ri, ob_busy);
        end
        while (dcyc < 0 && cyc < 400) begin
            if (hold_start) begin
                if (sel4) start4 = 1'b1;
                else      start1 = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (chk_ri && cyc <= 2 * nr) begin
                total++;
                if (int'(ob_ri) !== cyc) begin
                    bad++;
                    $display("FAIL round_seq: cycle %0d round_idx=%0d want %0d", cyc, ob_ri, cyc);
                end
            end
            if (cyc == 22) pt22 = ob_pt;
            if (ob_done === 1'b1) dcyc = cyc;
        end
        start1 = 1'b0;
        start4 = 1'b0;
        if (dcyc < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end else begin
            @(posedge clk);
            #1;
            total++;
            if (ob_done !== 1'b0 || ob_busy !== 1'b0) begin
                bad++;
                $display("FAIL after_done: done=%b busy=%b want 0/0", ob_done, ob_busy);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ri1, pt1, busy1, done1, pass1, err1, last1, disp1} !== '0) begin
            bad++;
            $display("FAIL reset_dut1: outputs=%0h want 0", {ri1, pt1, busy1, done1, pass1, err1});
        end
        total++;
        if ({ri4, pt4, busy4, done4, pass4, err4, last4, disp4} !== '0) begin
            bad++;
            $display("FAIL reset_dut4: outputs=%0h want 0", {ri4, pt4, busy4, done4, pass4, err4});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy1 !== 1'b0 || ri1 !== 6'd0) begin
            bad++;
            $display("FAIL idle_hold: busy=%b round_idx=%0d want 0/0", busy1, ri1);
        end
    endtask

    task automatic test_mode0();
        int d;
        logic [127:0] p;
        sel4 = 1'b0; core_mode = 2'd0; mode = 2'd0; seed = SEED;
        drive_start(1'b0);
        // Input changes during the run must not matter.
        mode = 2'd2;
        seed = '0;
        wait_done(10, 1'b1, 1'b0, d, p);
        total++;
        if (d !== 23) begin bad++; $display("FAIL m0_done_cycle: got %0d want 23", d); end
        total++;
        if (last1 !== C128) begin bad++; $display("FAIL m0_last_ct: got %h want %h", last1, C128); end
        total++;
        if (pass1 !== 1'b1 || err1 !== 1'b0) begin
            bad++;
            $display("FAIL m0_pass: pass=%b err=%0d want 1/0", pass1, err1);
        end
        disp_sel = 4'd0;  #1;
        total++;
        if (disp1 !== 8'h5a) begin bad++; $display("FAIL disp0: got %h want 5a", disp1); end
        disp_sel = 4'd5;  #1;
        total++;
        if (disp1 !== 8'hb7) begin bad++; $display("FAIL disp5: got %h want b7", disp1); end
        disp_sel = 4'd15; #1;
        total++;
        if (disp1 !== 8'h69) begin bad++; $display("FAIL disp15: got %h want 69", disp1); end
    endtask

    task automatic test_modes();
        int d;
        logic [127:0] p;
        logic [127:0] exp_ct [4];
        int exp_cyc [4];
        exp_ct  = '{C128, C192, C256, C256};
        exp_cyc = '{23, 27, 31, 31};
        sel4 = 1'b0; seed = SEED;
        for (int m = 1; m < 4; m++) begin
            core_mode = 2'(m);
            mode      = 2'(m);
            drive_start(1'b0);
            wait_done(nr_of(2'(m)), 1'b1, 1'b0, d, p);
            total++;
            if (d !== exp_cyc[m]) begin
                bad++;
                $display("FAIL mode%0d_done_cycle: got %0d want %0d", m, d, exp_cyc[m]);
            end
            total++;
            if (last1 !== exp_ct[m]) begin
                bad++;
                $display("FAIL mode%0d_last_ct: got %h want %h", m, last1, exp_ct[m]);
            end
        end
    endtask

    task automatic test_chain(input bit corrupt);
        int d;
        logic [127:0] p;
        logic [127:0] pts [5];
        pts[0] = SEED;
        for (int k = 0; k < 4; k++) pts[k+1] = fake_enc(pts[k], 2'd0);
        chain_last = pts[4];
        bad_a = pts[1];
        bad_b = pts[3];
        corrupt_en = corrupt;
        sel4 = 1'b1; core_mode = 2'd0; mode = 2'd0; seed = SEED;
        drive_start(1'b1);
        wait_done(10, 1'b0, 1'b0, d, p);
        corrupt_en = 1'b0;
        total++;
        if (d !== 89) begin bad++; $display("FAIL chain_done_cycle: got %0d want 89", d); end
        total++;
        if (p !== C128) begin bad++; $display("FAIL chain_pt_v1: got %h want %h", p, C128); end
        total++;
        if (last4 !== chain_last) begin
            bad++;
            $display("FAIL chain_last_ct: got %h want %h", last4, chain_last);
        end
        total++;
        if (pass4 !== !corrupt || err4 !== (corrupt ? 3'd2 : 3'd0)) begin
            bad++;
            $display("FAIL chain_result: pass=%b err=%0d want %b/%0d", pass4, err4, !corrupt,
                     corrupt ? 2 : 0);
        end
    endtask

    task automatic test_abort();
        int d;
        bit found = 1'b0;
        bit seen = 1'b0;
        logic [127:0] p;
        sel4 = 1'b1; core_mode = 2'd0; mode = 2'd0; seed = SEED;
        drive_start(1'b1);
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ri4 === 6'd7) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL abort_reach7: round_idx=%0d want 7", ri4); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        total++;
        if (busy4 !== 1'b0 || ri4 !== 6'd0 || pass4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: busy=%b ri=%0d pass=%b done=%b want 0/0/0/0", busy4, ri4,
                     pass4, done4);
        end
        total++;
        if (err4 !== 3'd0 || last4 !== chain_last) begin
            bad++;
            $display("FAIL abort_keep: err=%0d last=%h want 0/%h", err4, last4, chain_last);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done4 !== 1'b0 || busy4 !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL abort_quiet: done/busy=1 want 0 after abort"); end
        drive_start(1'b1);
        wait_done(10, 1'b1, 1'b0, d, p);
        total++;
        if (d !== 89 || pass4 !== 1'b1 || last4 !== chain_last) begin
            bad++;
            $display("FAIL abort_rerun: done=%0d pass=%b last=%h want 89/1/%h", d, pass4, last4,
                     chain_last);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        bit found = 1'b0;
        logic [127:0] p;
        sel4 = 1'b1; core_mode = 2'd0; mode = 2'd0; seed = SEED;
        @(negedge clk);
        start4 = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ri4 === 6'd15) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rst_reach15: round_idx=%0d want 15", ri4); end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({ri4, pt4, busy4, done4, pass4, err4, last4, disp4} !== '0 || last1 !== '0) begin
            bad++;
            $display("FAIL rst_midrun: ri=%0d busy=%b last4=%h last1=%h want all 0", ri4, busy4,
                     last4, last1);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold: busy=%b done=%b want 0/0", busy4, done4);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (pt4 !== SEED) begin bad++; $display("FAIL rst_restart_pt: got %h want %h", pt4, SEED); end
        // Start stays high for the whole run, including the cycle the sequencer sits in DONE.
        wait_done(10, 1'b1, 1'b1, d, p);
        total++;
        if (d !== 89 || pass4 !== 1'b1 || err4 !== 3'd0 || last4 !== chain_last) begin
            bad++;
            $display("FAIL b2b_run: done=%0d pass=%b err=%0d last=%h want 89/1/0/%h", d, pass4,
                     err4, last4, chain_last);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start1 = 1'b0; start4 = 1'b0; abort = 1'b0;
        mode = 2'd0; seed = '0; disp_sel = 4'd0;
        core_mode = 2'd0; corrupt_en = 1'b0; bad_a = '0; bad_b = '0;
        sel4 = 1'b0; chain_last = '0;
        test_reset();
        test_mode0();
        test_modes();
        test_chain(1'b0);
        test_chain(1'b1);
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
